subkey_stream: RTL and testbench

SUBKEY_STREAM -- requirements
Module: subkey_stream

---
 rtl/subkey_stream_pkg.sv | 42 ++++
 rtl/pc1.sv | 16 +
 rtl/pc2.sv | 19 +
 rtl/rotate28.sv | 20 ++
 rtl/subkey_stream.sv | 131 +++++++++++++
 tb/tb_subkey_stream.sv | 285 ++++++++++++++++++++++++++++
 6 files changed

// File: rtl/subkey_stream_pkg.sv
// Shared DES key-schedule tables: PC1, PC2 and the shift schedule.
// Also holds the subkey_stream state type.
package subkey_stream_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Bit n set when S[n+1] is 2, clear when it is 1.
  localparam logic [0:15] SHIFT_IS2 = 16'b0011_1111_0111_1110;

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // idx is zero-based: idx selects S[idx+1].
  function automatic logic shift_is2(
    input logic [3:0] idx
  );
    return SHIFT_IS2[idx];
  endfunction

endpackage

// File: rtl/pc1.sv
// DES permuted choice 1: 64-bit key to C/D halves.
// Ports: key [1:64] in; c_o, d_o [1:28] out.
module pc1
  import subkey_stream_pkg::*;
(
  input  logic [1:64] key,
  output logic [1:28] c_o,
  output logic [1:28] d_o
);

  for (genvar i = 0; i < 28; i++) begin : g_bit
    assign c_o[i+1] = key[7'(PC1_T[i])];
    assign d_o[i+1] = key[7'(PC1_T[i+28])];
  end

endmodule

// File: rtl/pc2.sv
// DES permuted choice 2: C/D halves to 48-bit subkey.
// Ports: c_i, d_i [1:28] in; k_o [1:48] out.
module pc2
  import subkey_stream_pkg::*;
(
  input  logic [1:28] c_i,
  input  logic [1:28] d_i,
  output logic [1:48] k_o
);

  logic [1:56] cd;

  assign cd = {c_i, d_i};

  for (genvar i = 0; i < 48; i++) begin : g_bit
    assign k_o[i+1] = cd[6'(PC2_T[i])];
  end

endmodule

// File: rtl/rotate28.sv
// 28-bit circular rotation by 1 or 2, left or right.
// Ports: din [1:28], two (amount 2), right (direction); dout [1:28].
module rotate28 (
  input  logic [1:28] din,
  input  logic        two,
  input  logic        right,
  output logic [1:28] dout
);

  always_comb begin
    dout = din;
    unique case ({right, two})
      2'b00: dout = {din[2:28], din[1]};
      2'b01: dout = {din[3:28], din[1:2]};
      2'b10: dout = {din[28], din[1:27]};
      2'b11: dout = {din[27:28], din[1:26]};
    endcase
  end

endmodule

// File: rtl/subkey_stream.sv
// Streams the 16 DES round subkeys over a valid/ready handshake.
// Ports: clk, rst_n, start, decrypt, key, abort, subkey_ready in;
//        subkey_valid, subkey, round, last, busy, done out.
module subkey_stream
  import subkey_stream_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        decrypt,
  input  logic [1:64] key,
  input  logic        abort,
  input  logic        subkey_ready,
  output logic        subkey_valid,
  output logic [1:48] subkey,
  output logic [3:0]  round,
  output logic        last,
  output logic        busy,
  output logic        done
);

  state_e      state_q, state_d;
  logic [1:28] c_q, c_d;
  logic [1:28] d_q, d_d;
  logic [3:0]  round_q, round_d;
  logic        dec_q, dec_d;
  logic        done_q, done_d;

  logic [1:28] pc1_c, pc1_d;
  logic [1:28] rot_c_in, rot_d_in;
  logic [1:28] rot_c, rot_d;
  logic [3:0]  sidx;
  logic        run, rot_two, rot_right;

  assign run = (state_q == RUN);

  // The rotators are shared: in IDLE they produce C1/D1
  // from PC1, in RUN they step the registered halves.
  assign sidx = dec_q ? (4'd15 - round_q)
                      : (round_q + 4'd1);
  assign rot_two   = run & shift_is2(sidx);
  assign rot_right = run & dec_q;
  assign rot_c_in  = run ? c_q : pc1_c;
  assign rot_d_in  = run ? d_q : pc1_d;

  pc1 u_pc1 (
    .key (key),
    .c_o (pc1_c),
    .d_o (pc1_d)
  );

  rotate28 u_rot_c (
    .din   (rot_c_in),
    .two   (rot_two),
    .right (rot_right),
    .dout  (rot_c)
  );

  rotate28 u_rot_d (
    .din   (rot_d_in),
    .two   (rot_two),
    .right (rot_right),
    .dout  (rot_d)
  );

  pc2 u_pc2 (
    .c_i (c_q),
    .d_i (d_q),
    .k_o (subkey)
  );

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    round_d = round_q;
    dec_d   = dec_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = RUN;
          round_d = 4'd0;
          dec_d   = decrypt;
          // C16/D16 equal C0/D0, so decrypt starts unrotated.
          c_d     = decrypt ? pc1_c : rot_c;
          d_d     = decrypt ? pc1_d : rot_d;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (subkey_ready) begin
          if (round_q == 4'd15) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            c_d     = rot_c;
            d_d     = rot_d;
            round_d = round_q + 4'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
      dec_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      round_q <= round_d;
      dec_q   <= dec_d;
      done_q  <= done_d;
    end
  end

  assign subkey_valid = run;
  assign busy         = run;
  assign round        = round_q;
  assign last         = run & (round_q == 4'd15);
  assign done         = done_q;

endmodule

// File: tb/tb_subkey_stream.sv
// Randomised bench for subkey_stream with a behavioural
// key-schedule model and per-cycle comparison.
module tb_subkey_stream;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        decrypt = 1'b0;
  logic [1:64] key = '0;
  logic        abort = 1'b0;
  logic        subkey_ready = 1'b0;
  logic        subkey_valid;
  logic [1:48] subkey;
  logic [3:0]  round;
  logic        last;
  logic        busy;
  logic        done;

  int n_pass = 0;
  int n_total = 0;

  localparam logic [1:64] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [1:64] KEY_B = 64'h0123456789ABCDEF;
  localparam logic [1:48] K1_A  = 48'h1B02EFFC7072;
  localparam logic [1:48] K16_A = 48'hCB3D8B0E17F5;

  int T_S [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  int T_PC1 [56] = '{
    57,49,41,33,25,17, 9, 1,58,50,42,34,26,18,
    10, 2,59,51,43,35,27,19,11, 3,60,52,44,36,
    63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
    14, 6,61,53,45,37,29,21,13, 5,28,20,12, 4};

  int T_PC2 [48] = '{
    14,17,11,24, 1, 5, 3,28,15, 6,21,10,
    23,19,12, 4,26, 8,16, 7,27,20,13, 2,
    41,52,31,37,47,55,30,40,51,45,33,48,
    44,49,39,56,34,53,46,42,50,36,29,32};

  subkey_stream dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .decrypt      (decrypt),
    .key          (key),
    .abort        (abort),
    .subkey_ready (subkey_ready),
    .subkey_valid (subkey_valid),
    .subkey       (subkey),
    .round        (round),
    .last         (last),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // K_n straight from the definition: C_n/D_n are C0/D0
  // rotated left by the running sum of S[1..n].
  function automatic logic [1:48] ref_k(
    input logic [1:64] k,
    input int n
  );
    logic [1:56] cd0;
    logic [1:56] cd;
    logic [1:48] r;
    int tot;
    for (int i = 0; i < 56; i++)
      cd0[6'(i+1)] = k[7'(T_PC1[i])];
    tot = 0;
    for (int j = 1; j <= n; j++)
      tot += T_S[j-1];
    for (int b = 0; b < 28; b++) begin
      cd[6'(b+1)]  = cd0[6'(((b+tot)%28)+1)];
      cd[6'(b+29)] = cd0[6'(((b+tot)%28)+29)];
    end
    for (int i = 0; i < 48; i++)
      r[6'(i+1)] = cd[6'(T_PC2[i])];
    return r;
  endfunction

  task automatic chk(
    input string nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Scoreboard state
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  int          m_idx = 0;
  logic [1:48] m_seq [16];

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_valid", 64'(subkey_valid), 0);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_done", 64'(done), 0);
      chk("rst_last", 64'(last), 0);
      chk("rst_round", 64'(round), 0);
      chk("rst_subkey", 64'(subkey), 0);
      m_busy = 1'b0;
      m_done = 1'b0;
    end else begin
      chk("valid", 64'(subkey_valid), 64'(m_busy));
      chk("busy", 64'(busy), 64'(m_busy));
      chk("done", 64'(done), 64'(m_done));
      if (m_busy) begin
        chk("round", 64'(round), 64'(m_idx));
        chk("last", 64'(last), 64'(m_idx == 15));
        chk("subkey", 64'(subkey), 64'(m_seq[4'(m_idx)]));
      end
      m_done = 1'b0;
      if (!m_busy) begin
        if (start && !abort) begin
          m_busy = 1'b1;
          m_idx = 0;
          for (int e = 0; e < 16; e++)
            m_seq[e] = decrypt ? ref_k(key, 16 - e)
                               : ref_k(key, e + 1);
        end
      end else if (abort) begin
        m_busy = 1'b0;
      end else if (subkey_ready) begin
        if (m_idx == 15) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end else begin
          m_idx++;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(
    input logic [1:64] k,
    input logic dec
  );
    key = k;
    decrypt = dec;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // Random ready plus start/key/decrypt noise while busy.
  task automatic run_to_done(input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      subkey_ready = 1'($urandom_range(0, 1));
      start = ($urandom_range(0, 3) == 0);
      key = {$urandom, $urandom};
      decrypt = 1'($urandom_range(0, 1));
      cyc();
      if (done) begin
        ok = 1;
        break;
      end
    end
    start = 1'b0;
    chk("done_seen", 64'(ok), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    chk("model_k1", 64'(ref_k(KEY_A, 1)), 64'(K1_A));
    chk("model_k16", 64'(ref_k(KEY_A, 16)), 64'(K16_A));

    repeat (3) cyc();
    chk("por_valid", 64'(subkey_valid), 0);
    chk("por_subkey", 64'(subkey), 0);
    rst_n = 1'b1;
    cyc();

    // Encrypt, ready tied high
    subkey_ready = 1'b1;
    do_start(KEY_A, 1'b0);
    chk("enc_lat", 64'(subkey_valid), 1);
    chk("enc_k1", 64'(subkey), 64'(K1_A));
    repeat (15) cyc();
    chk("enc_r15", 64'(round), 15);
    chk("enc_k16", 64'(subkey), 64'(K16_A));
    chk("enc_last", 64'(last), 1);
    cyc();
    chk("enc_done", 64'(done), 1);
    chk("enc_idle", 64'(subkey_valid), 0);
    cyc();
    chk("enc_done_pulse", 64'(done), 0);

    // Decrypt, ready tied high
    do_start(KEY_A, 1'b1);
    chk("dec_k16", 64'(subkey), 64'(K16_A));
    repeat (15) cyc();
    chk("dec_k1", 64'(subkey), 64'(K1_A));
    chk("dec_last", 64'(last), 1);
    cyc();
    chk("dec_done", 64'(done), 1);
    cyc();

    // Random keys, modes and back-pressure
    for (int t = 0; t < 6; t++) begin
      do_start({$urandom, $urandom}, 1'($urandom_range(0, 1)));
      run_to_done(400);
      cyc();
    end

    // Abort at round 7 with ready high
    subkey_ready = 1'b1;
    do_start({$urandom, $urandom}, 1'b0);
    repeat (7) cyc();
    chk("ab_r7", 64'(round), 7);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("ab_valid", 64'(subkey_valid), 0);
    cyc();
    chk("ab_nodone", 64'(done), 0);
    do_start(KEY_B, 1'b0);
    chk("kb_k1", 64'(subkey), 64'(ref_k(KEY_B, 1)));
    run_to_done(400);
    cyc();

    // Start while busy is ignored, then reset at round 9
    subkey_ready = 1'b1;
    do_start(KEY_A, 1'b1);
    subkey_ready = 1'b0;
    key = KEY_B;
    decrypt = 1'b0;
    start = 1'b1;
    cyc();
    cyc();
    start = 1'b0;
    chk("busy_start", 64'(subkey), 64'(K16_A));
    subkey_ready = 1'b1;
    repeat (9) cyc();
    chk("rs_r9", 64'(round), 9);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_valid", 64'(subkey_valid), 0);
    chk("rs_subkey", 64'(subkey), 0);
    chk("rs_round", 64'(round), 0);
    chk("rs_busy", 64'(busy), 0);
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("rs_nodone", 64'(done), 0);

    // start with abort in IDLE is ignored
    key = KEY_A;
    start = 1'b1;
    abort = 1'b1;
    cyc();
    start = 1'b0;
    abort = 1'b0;
    chk("sa_idle", 64'(subkey_valid), 0);
    cyc();

    do_start(KEY_A, 1'b0);
    chk("post_k1", 64'(subkey), 64'(K1_A));
    run_to_done(400);
    repeat (2) cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
